// File: rtl/sipo_frame_rx_if.sv
// ============================================================================
//  Module      : sipo_frame_rx_if
//  Description : Output handshake bundle of the serial frame receiver. Carries
//                the recovered data word and its valid/ready handshake.
//  Signals     : out   - received data word, DW-2 bits
//                valid - out holds an unconsumed word (driven by the receiver)
//                ready - downstream accepts the word (driven by the consumer)
//  Modports    : master - receiver side (drives out/valid, samples ready)
//                slave  - consumer side (samples out/valid, drives ready)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sipo_frame_rx_if #(
    parameter int DW = 10
);
    logic [DW-3:0] out;
    logic          valid;
    logic          ready;

    modport master (
        output out,
        output valid,
        input  ready
    );

    modport slave (
        input  out,
        input  valid,
        output ready
    );
endinterface

`default_nettype wire

// File: rtl/sipo_frame_rx.sv
// ============================================================================
//  Module      : sipo_frame_rx
//  Description : Serial frame receiver paired with an MSB-first PISO
//                transmitter. Samples the idle-high line once per enb strobe,
//                recovers frames of DW bits (start 0, DW-2 data bits MSB
//                first, stop 1) and presents each good word on a registered
//                valid/ready output. Bad stop bits raise frame_err; good
//                frames arriving while the previous word is still held raise
//                overrun and are dropped.
//  Parameters  : DW        - total frame bits incl. start and stop (DW >= 3)
//  Ports       : clk       - system clock
//                reset     - asynchronous reset, active-low
//                enb       - one-clk bit strobe shared with the transmitter
//                inp       - serial line, idle high
//                clr       - synchronous restart, active-high, top priority
//                bus       - master modport: out / valid / ready
//                frame_err - one-cycle pulse, stop bit sampled as 0
//                overrun   - one-cycle pulse, good frame dropped
//  Option      : define SIPO_FRAME_RX_SYNC_EN to pass inp through a 2-flop
//                synchronizer and delay enb by the same 2 flops; all timing
//                then shifts 2 clk later.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_frame_rx #(
    parameter int DW = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enb,
    input  logic            inp,
    input  logic            clr,
    sipo_frame_rx_if.master bus,
    output logic            frame_err,
    output logic            overrun
);

    localparam int DATA_W = DW - 2;
    localparam int CNT_W  = $clog2(DW);

    // Counter value on the enb that captures the last data bit.
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DW - 3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STOP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Line conditioning: optional synchronizer on inp with a matching delay
    // on enb so each strobe still lines up with the bit it was meant to hit.
    // ------------------------------------------------------------------------
    logic w_inp;
    logic w_enb;

`ifdef SIPO_FRAME_RX_SYNC_EN
    logic [1:0] r_inp_sync;
    logic [1:0] r_enb_pipe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inp_sync <= 2'b11;
            r_enb_pipe <= 2'b00;
        end else if (clr) begin
            r_inp_sync <= 2'b11;
            r_enb_pipe <= 2'b00;
        end else begin
            r_inp_sync <= {r_inp_sync[0], inp};
            r_enb_pipe <= {r_enb_pipe[0], enb};
        end
    end

    assign w_inp = r_inp_sync[1];
    assign w_enb = r_enb_pipe[1];
`else
    assign w_inp = inp;
    assign w_enb = enb;
`endif

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_shreg;
    logic [DATA_W-1:0]   r_out;
    logic                r_valid;
    logic                r_frame_err;
    logic                r_overrun;
    // Stop-bit outcome, acted on one clk after the stop sample.
    logic                r_good_pend;
    logic                r_bad_pend;

    logic [DATA_W-1:0]   w_shreg_next;

    // A one-bit data word has nothing to shift through.
    generate
        if (DATA_W == 1) begin : g_shift_single
            assign w_shreg_next = w_inp;
        end else begin : g_shift_wide
            assign w_shreg_next = {r_shreg[DATA_W-2:0], w_inp};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_out       <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_good_pend <= 1'b0;
            r_bad_pend  <= 1'b0;
        end else if (clr) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_out       <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_good_pend <= 1'b0;
            r_bad_pend  <= 1'b0;
        end else begin
            r_good_pend <= 1'b0;
            r_bad_pend  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= r_bad_pend;

            // Delivery stage. A word consumed on this edge makes room for the
            // pending frame; otherwise the pending frame is dropped.
            if (r_good_pend) begin
                if (!r_valid || bus.ready) begin
                    r_out   <= r_shreg;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && bus.ready) begin
                r_valid <= 1'b0;
            end

            // Bit-level FSM, advances only on strobes. The shift register is
            // untouched on the start-bit edge, so a back-to-back frame cannot
            // disturb the word the delivery stage is about to copy.
            if (w_enb) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_inp) begin
                            r_state <= ST_SHIFT;
                            r_cnt   <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        r_shreg <= w_shreg_next;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_last_bit) begin
                            r_state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        r_good_pend <= w_inp;
                        r_bad_pend  <= !w_inp;
                        r_state     <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.out   = r_out;
    assign bus.valid = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

`ifndef SYNTHESIS
    // The two flags come from mutually exclusive stop-bit outcomes.
    a_flags_exclusive : assert property (
        @(posedge clk) disable iff (!reset) !(r_frame_err && r_overrun)
    );

    // A held word may not change until it is consumed.
    a_out_stable : assert property (
        @(posedge clk) disable iff (!reset)
        (r_valid && !bus.ready && !clr) |=> $stable(r_out)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_sipo_frame_rx.sv
// ============================================================================
//  Module      : tb_sipo_frame_rx
//  Description : Testbench for sipo_frame_rx. A driver process plays the
//                transmitter (frames from a queue, shared enb strobe) and
//                keeps a frame-level reference model; expected words and flag
//                pulses go into queues that a negedge monitor checks against
//                the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_frame_rx;

    localparam int DW     = 10;
    localparam int DATA_W = DW - 2;
`ifdef SIPO_FRAME_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int K_ERR = 1;
    localparam int K_OVR = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic enb   = 1'b0;
    logic inp   = 1'b1;
    logic clr   = 1'b0;
    logic ready = 1'b0;
    logic frame_err;
    logic overrun;

    sipo_frame_rx_if #(.DW(DW)) bus ();
    assign bus.ready = ready;

    sipo_frame_rx #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enb       (enb),
        .inp       (inp),
        .clr       (clr),
        .bus       (bus),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              stop;
        int                gap;
    } frame_t;

    typedef struct {
        int unsigned       due;
        logic              good;
        logic [DATA_W-1:0] data;
    } pend_t;

    typedef struct {
        int          kind;
        int unsigned at;
    } flag_t;

    frame_t            txq[$];
    pend_t             pq[$];
    logic [DATA_W-1:0] wq[$];
    flag_t             fq[$];

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;

    // Controls written by the main sequence only.
    int enb_per    = 4;
    int ready_mode = 1;  // 0 low, 1 high, 2 random, 3 high only on delivery edges
    int clr_tok    = 0;

    // Driver/model state written by the driver only.
    logic tx_busy   = 1'b0;
    int   bits_sent = 0;
    logic m_full    = 1'b0;

    // Observation counters written by the monitor only.
    int n_words = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic s, input int g);
        frame_t f;
        f.data = d;
        f.stop = s;
        f.gap  = g;
        txq.push_back(f);
    endtask

    // ------------------------------------------------------------------------
    // Driver + reference model. At posedge+1 it first applies the frame-level
    // rules to the edge that just happened, then picks inputs for the next.
    // ------------------------------------------------------------------------
    initial begin : driver
        logic              enb_n, inp_n, clr_n, ready_n, load;
        logic [DW-1:0]     cur_bits;
        logic [DATA_W-1:0] cur_data;
        logic              cur_stop;
        int                gap_left;
        int                enb_cnt;
        int                clr_seen;
        frame_t            f;
        pend_t             p;
        flag_t             fl;
        gap_left = 0;
        enb_cnt  = 0;
        clr_seen = 0;
        cur_bits = '1;
        cur_data = '0;
        cur_stop = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!reset || clr) begin
                m_full  = 1'b0;
                tx_busy = 1'b0;
                pq.delete();
                wq.delete();
                fq.delete();
            end else begin
                load = 1'b0;
                if (pq.size() != 0 && pq[0].due == cyc) begin
                    p = pq.pop_front();
                    fl.at = cyc;
                    if (!p.good) begin
                        fl.kind = K_ERR;
                        fq.push_back(fl);
                    end else if (!m_full || ready) begin
                        wq.push_back(p.data);
                        load = 1'b1;
                    end else begin
                        fl.kind = K_OVR;
                        fq.push_back(fl);
                    end
                end
                if (load) m_full = 1'b1;
                else if (m_full && ready) m_full = 1'b0;
            end

            clr_n    = (clr_tok != clr_seen);
            clr_seen = clr_tok;
            enb_n    = 1'b0;
            if (enb_cnt >= enb_per - 1) begin
                enb_n   = 1'b1;
                enb_cnt = 0;
            end else begin
                enb_cnt++;
            end
            inp_n = inp;
            if (clr_n || !reset) begin
                tx_busy = 1'b0;
                inp_n   = 1'b1;
            end else if (enb_n) begin
                if (!tx_busy && txq.size() != 0) begin
                    f         = txq.pop_front();
                    cur_data  = f.data;
                    cur_stop  = f.stop;
                    cur_bits  = {1'b0, f.data, f.stop};
                    gap_left  = f.gap;
                    bits_sent = 0;
                    tx_busy   = 1'b1;
                end
                if (!tx_busy) begin
                    inp_n = 1'b1;
                end else if (gap_left > 0) begin
                    inp_n = 1'b1;
                    gap_left--;
                end else begin
                    inp_n = cur_bits[DW-1-bits_sent];
                    bits_sent++;
                    if (bits_sent == DW) begin
                        tx_busy = 1'b0;
                        p.due   = cyc + 2 + SYNC_LAT;
                        p.good  = cur_stop;
                        p.data  = cur_data;
                        pq.push_back(p);
                    end
                end
            end

            case (ready_mode)
                0:       ready_n = 1'b0;
                1:       ready_n = 1'b1;
                2:       ready_n = ($urandom_range(0, 2) != 0);
                default: ready_n = (pq.size() != 0 && pq[0].due == cyc + 1);
            endcase
            enb   = enb_n;
            inp   = inp_n;
            clr   = clr_n;
            ready = ready_n;
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: mid-cycle comparison of DUT outputs against the scoreboard.
    // ------------------------------------------------------------------------
    task automatic check_flag(input int kind, input string name);
        checks++;
        if (fq.size() != 0 && fq[0].at == cyc && fq[0].kind == kind) begin
            void'(fq.pop_front());
        end else begin
            errors++;
            $display("FAIL %s: got unexpected pulse at cycle %0d", name, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            while (fq.size() != 0 && fq[0].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL flag_missing: kind %0d expected at cycle %0d, got none", fq[0].kind, fq[0].at);
                void'(fq.pop_front());
            end
            chk("valid", {31'd0, bus.valid}, {31'd0, m_full});
            if (bus.valid) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected: got out=%0h, expected no word", bus.out);
                end else begin
                    chk("out", 32'(bus.out), 32'(wq[0]));
                    if (ready) begin
                        void'(wq.pop_front());
                        n_words++;
                    end
                end
            end
            if (frame_err) begin
                n_ferr++;
                check_flag(K_ERR, "frame_err");
            end
            if (overrun) begin
                n_ovr++;
                check_flag(K_OVR, "overrun");
            end
        end
    end

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((txq.size() != 0 || tx_busy || pq.size() != 0) && n < limit) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles, required idle", n);
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic wait_bits(input int nbits);
        int n;
        n = 0;
        while (!(tx_busy && bits_sent == nbits) && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL bits_timeout: got %0d bits sent, required %0d", bits_sent, nbits);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, required completion before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w0, e0, o0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_out", 32'(bus.out), 32'd0);
        chk("reset_valid", {31'd0, bus.valid}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        chk("reset_ovr", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;

        // Loopback of a single frame.
        ready_mode = 1;
        w0 = n_words; e0 = n_ferr;
        send(8'hA5, 1'b1, 2);
        wait_idle(300);
        chk("loop_words", n_words - w0, 1);
        chk("loop_ferr", n_ferr - e0, 0);

        // Framing error followed by a good frame.
        w0 = n_words; e0 = n_ferr;
        send(8'h3C, 1'b0, 1);
        send(8'h81, 1'b1, 0);
        wait_idle(300);
        chk("ferr_count", n_ferr - e0, 1);
        chk("ferr_words", n_words - w0, 1);

        // Backpressure and overrun.
        ready_mode = 0;
        o0 = n_ovr; w0 = n_words;
        send(8'h11, 1'b1, 1);
        send(8'h22, 1'b1, 0);
        wait_idle(300);
        chk("ovr_count", n_ovr - o0, 1);
        chk("ovr_held_out", 32'(bus.out), 32'h11);
        chk("ovr_held_valid", {31'd0, bus.valid}, 32'd1);
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("ovr_drain_words", n_words - w0, 1);
        chk("ovr_drain_valid", {31'd0, bus.valid}, 32'd0);

        // Transfer and new load on the same edge.
        ready_mode = 3;
        o0 = n_ovr; w0 = n_words;
        send(8'h11, 1'b1, 1);
        wait_idle(300);
        send(8'h22, 1'b1, 1);
        wait_idle(300);
        chk("simul_ovr", n_ovr - o0, 0);
        chk("simul_out", 32'(bus.out), 32'h22);
        chk("simul_valid", {31'd0, bus.valid}, 32'd1);
        chk("simul_words", n_words - w0, 1);
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #2;

        // Soft restart after four data bits.
        w0 = n_words;
        send(8'h96, 1'b1, 1);
        wait_bits(5);
        repeat (3) @(posedge clk);
        clr_tok++;
        repeat (3) @(posedge clk);
        #2;
        chk("clr_valid", {31'd0, bus.valid}, 32'd0);
        send(8'hF0, 1'b1, 3);
        wait_idle(300);
        chk("clr_words", n_words - w0, 1);

        // Asynchronous reset in the middle of a frame while a word is held.
        ready_mode = 0;
        send(8'h33, 1'b1, 1);
        wait_idle(300);
        send(8'hC3, 1'b1, 1);
        wait_bits(4);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_out", 32'(bus.out), 32'd0);
        chk("arst_valid", {31'd0, bus.valid}, 32'd0);
        chk("arst_ferr", {31'd0, frame_err}, 32'd0);
        chk("arst_ovr", {31'd0, overrun}, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        ready_mode = 1;
        w0 = n_words;
        send(8'h5A, 1'b1, 2);
        wait_idle(300);
        chk("arst_words", n_words - w0, 1);

        // Randomized traffic at several strobe rates.
        ready_mode = 2;
        for (int b = 0; b < 3; b++) begin
            enb_per = (b == 0) ? 4 : ((b == 1) ? 1 : 3);
            for (int i = 0; i < 15; i++) begin
                send(DATA_W'($urandom), ($urandom_range(0, 4) != 0), $urandom_range(0, 2));
            end
            wait_idle(3000);
        end
        ready_mode = 1;
        repeat (6) @(posedge clk);
        #2;
        chk("final_words_left", wq.size(), 0);
        chk("final_flags_left", fq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
